case_3_sdiv_7s_4s_seq: RTL and testbench

CASE_3_SDIV_7S_4S_SEQ -- requirements
Module: case_3_sdiv_7s_4s_seq

---
 rtl/case_3_sdiv_pkg.sv | 21 ++
 rtl/case_3_sdiv_step.sv | 23 ++
 rtl/case_3_sdiv_7s_4s_seq.sv | 131 +++++++++++++
 tb/tb_case_3_sdiv_7s_4s_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/case_3_sdiv_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding and default widths.
package case_3_sdiv_pkg;

  localparam int DIN0_WIDTH_DEF = 7;
  localparam int DIN1_WIDTH_DEF = 4;
  localparam int DOUT_WIDTH_DEF = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE
  } state_t;

  // Bits needed for an iteration counter that runs 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/case_3_sdiv_step.sv
// One restoring shift-subtract step on unsigned magnitudes; purely combinational.
module case_3_sdiv_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] divisor,
  input  logic         bit_in,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[W];
    rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/case_3_sdiv_7s_4s_seq.sv
// Sequential signed divider (truncating toward zero), one quotient bit per cycle.
// Define CASE_3_SDIV_DIVZERO_FLAG_EN to add the dz divide-by-zero flag output.
module case_3_sdiv_7s_4s_seq
  import case_3_sdiv_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = DOUT_WIDTH_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         start,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         busy,
  output logic                         done,
  output logic        [dout_WIDTH-1:0] dout,
  output logic        [din1_WIDTH-1:0] rem
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
  ,
  output logic                         dz
`endif
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int CW = cnt_width(din0_WIDTH);

  state_t                state;
  logic signed [W0-1:0]  a_reg;
  logic signed [W1-1:0]  b_reg;
  logic                  sign_a;
  logic                  sign_b;
  logic        [W0-1:0]  dvd;
  logic        [W1-1:0]  dsr;
  logic        [W1-1:0]  prem;
  logic        [W1-1:0]  prem_next;
  logic                  q_bit;
  logic        [CW-1:0]  cnt;
  logic        [W0-1:0]  a_mag;
  logic        [W1-1:0]  b_mag;

  always_comb begin
    a_mag = a_reg[W0-1] ? (~a_reg + W0'(1)) : a_reg;
    b_mag = b_reg[W1-1] ? (~b_reg + W1'(1)) : b_reg;
  end

  case_3_sdiv_step #(.W(W1)) u_step (
    .rem_in  (prem),
    .divisor (dsr),
    .bit_in  (dvd[W0-1]),
    .rem_out (prem_next),
    .q_bit   (q_bit)
  );

  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom,
  // so after W0 steps it holds the quotient magnitude.
  // NOTE: all state, including the datapath registers, is reset so no X ever reaches the outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dvd    <= '0;
      dsr    <= '0;
      prem   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      rem    <= '0;
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
      dz     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= din0;
            b_reg <= din1;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          dvd    <= a_mag;
          dsr    <= b_mag;
          sign_a <= a_reg[W0-1];
          sign_b <= b_reg[W1-1];
          prem   <= '0;
          cnt    <= '0;
          state  <= CALC;
        end
        CALC: begin
          prem <= prem_next;
          dvd  <= {dvd[W0-2:0], q_bit};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(W0 - 1)) state <= FIX;
        end
        FIX: begin
          if (b_reg == '0) begin
            dout <= '1;
            rem  <= a_reg[W1-1:0];
          end else begin
            dout <= dout_WIDTH'((sign_a ^ sign_b) ? (~dvd + W0'(1)) : dvd);
            rem  <= sign_a ? (~prem + W1'(1)) : prem;
          end
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
          dz    <= (b_reg == '0);
`endif
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
          dz    <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_3_sdiv_7s_4s_seq.sv
// Self-checking bench for case_3_sdiv_7s_4s_seq: cycle-level reference model plus directed literal cases.
module tb_case_3_sdiv_7s_4s_seq;

  localparam int W0  = 7;
  localparam int W1  = 4;
  localparam int LAT = W0 + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic signed [6:0] din0 = '0;
  logic signed [3:0] din1 = '0;
  logic              busy;
  logic              done;
  logic        [6:0] dout;
  logic        [3:0] rem;
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
  logic              dz;
`endif

  int tests = 0;
  int fails = 0;

  case_3_sdiv_7s_4s_seq #(
    .ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(W0)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .rem      (rem)
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
    ,
    .dz       (dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer division: SystemVerilog '/' and '%' on int truncate toward zero.
  function automatic void ref_div(input logic signed [6:0] a, input logic signed [3:0] b,
                                  output logic [6:0] q, output logic [3:0] r);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = '1;
      r = a[3:0];
    end else begin
      q = 7'(ai / bi);
      r = 4'(ai % bi);
    end
  endfunction

  // Reference model: an accepted request keeps busy high for LAT cycles, the last of
  // which carries done; results appear with done and hold afterwards.
  int         busy_left = 0;
  logic [6:0] pend_q = '0, exp_dout = '0;
  logic [3:0] pend_r = '0, exp_rem = '0;
  logic       pend_z = 1'b0, exp_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left <= 0;
      exp_dout  <= '0;
      exp_rem   <= '0;
      exp_dz    <= 1'b0;
    end else if (busy_left == 0) begin
      if (start) begin
        logic [6:0] q;
        logic [3:0] r;
        ref_div(din0, din1, q, r);
        pend_q    <= q;
        pend_r    <= r;
        pend_z    <= (din1 == 0);
        busy_left <= LAT;
      end
    end else begin
      busy_left <= busy_left - 1;
      if (busy_left == 2) begin
        exp_dout <= pend_q;
        exp_rem  <= pend_r;
        exp_dz   <= pend_z;
      end
      if (busy_left == 1) exp_dz <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, busy_left != 0);
    check("done", done, busy_left == 1);
    check("dout", dout, exp_dout);
    check("rem", rem, exp_rem);
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
    check("dz", dz, exp_dz);
`endif
  end

  task automatic wait_idle();
    for (int n = 0; n < 3 * LAT && busy; n++) @(negedge clk);
  endtask

  // Issues one request at a negedge and checks latency, busy width and literal results.
  task automatic do_op(input string name, input logic signed [6:0] a, input logic signed [3:0] b,
                       input logic [6:0] eq, input logic [3:0] er, input logic ez);
    int n;
    int bc;
    wait_idle();
    din0  = a;
    din1  = b;
    start = 1'b1;
    bc    = 0;
    for (n = 1; n <= 3 * LAT; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) break;
    end
    check({name, " latency"}, n, LAT);
    check({name, " busy cycles"}, bc, LAT);
    check({name, " dout"}, dout, eq);
    check({name, " rem"}, rem, er);
`ifdef CASE_3_SDIV_DIVZERO_FLAG_EN
    check({name, " dz"}, dz, ez);
`else
    if (ez) check({name, " no dz port, flag unused"}, 32'd0, 32'd0 + tests - tests);
`endif
    @(negedge clk);
    check({name, " busy after done"}, busy, 1'b0);
  endtask

  initial begin
    int dcount;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dout", dout, 7'd0);
    check("reset rem", rem, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("50/7", 7'sd50, 4'sd7, 7'd7, 4'd1, 1'b0);
    do_op("-50/7", -7'sd50, 4'sd7, 7'h79, 4'hF, 1'b0);
    do_op("50/-7", 7'sd50, -4'sd7, 7'h79, 4'h1, 1'b0);
    do_op("-50/-7", -7'sd50, -4'sd7, 7'd7, 4'hF, 1'b0);
    do_op("-64/-1", -7'sd64, -4'sd1, 7'h40, 4'h0, 1'b0);
    do_op("13/0", 7'sd13, 4'sd0, 7'h7F, 4'hD, 1'b1);
    do_op("-64/-8", -7'sd64, -4'sd8, 7'd8, 4'h0, 1'b0);
    do_op("63/-8", 7'sd63, -4'sd8, 7'h79, 4'h7, 1'b0);

    // A second start during CALC must be dropped, leaving one done with the first result.
    wait_idle();
    din0 = 7'sd45; din1 = 4'sd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    din0 = -7'sd9; din1 = 4'sd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int n = 0; n < 2 * LAT; n++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        check("ignored start dout", dout, 7'd11);
        check("ignored start rem", rem, 4'd1);
      end
    end
    check("ignored start done count", dcount, 1);

    // Reset pulse in the middle of CALC clears outputs immediately and aborts the operation.
    wait_idle();
    din0 = 7'sd33; din1 = 4'sd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 1'b0);
    check("async rst done", done, 1'b0);
    check("async rst dout", dout, 7'd0);
    check("async rst rem", rem, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int n = 0; n < 2 * LAT; n++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("aborted op done count", dcount, 0);
    do_op("20/3 after reset", 7'sd20, 4'sd3, 7'd6, 4'd2, 1'b0);

    // Random requests, with the corner operands injected often.
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 2) == 0);
      din0  = ($urandom_range(0, 7) == 0) ? -7'sd64 : 7'($urandom);
      case ($urandom_range(0, 7))
        0:       din1 = 4'sd0;
        1:       din1 = -4'sd1;
        2:       din1 = -4'sd8;
        default: din1 = 4'($urandom);
      endcase
      @(negedge clk);
    end

    // start held high: each operation is accepted in the IDLE cycle right after done.
    start = 1'b1;
    for (int n = 0; n < 80; n++) begin
      din0 = 7'($urandom);
      din1 = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2 * LAT) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
